ycbcr_frame_ctrl: RTL and testbench

YCBCR_FRAME_CTRL -- requirements
Module: ycbcr_frame_ctrl

---
 rtl/ycbcr_frame_ctrl.sv | 124 ++++++++++++
 tb/tb_ycbcr_frame_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_frame_ctrl.sv
// Frame controller around an external RGB-to-YCbCr converter: accepts one frame of RGB
// pixels, drives the converter and tags its results with valid/sof/eol/eof.
module ycbcr_frame_ctrl #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned CONV_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_red,
  input  logic [7:0] s_green,
  input  logic [7:0] s_blue,
  output logic [7:0] red_ch,
  output logic [7:0] green_ch,
  output logic [7:0] blue_ch,
  input  logic [7:0] luma_ch,
  input  logic [7:0] cb_ch,
  input  logic [7:0] cr_ch,
  output logic       m_valid,
  output logic [7:0] m_luma,
  output logic [7:0] m_cb,
  output logic [7:0] m_cr,
  output logic       m_sof,
  output logic       m_eol,
  output logic       m_eof
);

  localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned Depth = CONV_LAT + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [3:0]    tag_q [Depth];  // {valid, sof, eol, eof}

  logic accept, sof, eol, eof, abort_act, start_act;

  assign accept    = s_valid && s_ready;
  assign sof       = (col_q == '0) && (row_q == '0);
  assign eol       = (col_q == CW'(IMG_W - 1));
  assign eof       = eol && (row_q == RW'(IMG_H - 1));
  assign abort_act = abort && ((state_q == StRun) || (state_q == StDrain));
  // Abort beats a simultaneous start.
  assign start_act = start && !abort && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_act) state_d = StRun;
      StRun: begin
        if (abort)               state_d = StIdle;
        else if (accept && eof)  state_d = StDrain;
      end
      StDrain: begin
        if (abort)      state_d = StIdle;
        else if (m_eof) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || abort_act || start_act) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (eol) begin
        col_q <= '0;
        row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_ch   <= '0;
      green_ch <= '0;
      blue_ch  <= '0;
    end else if (accept) begin
      red_ch   <= s_red;
      green_ch <= s_green;
      blue_ch  <= s_blue;
    end
  end

  // Tag pipeline tracks the converter so flags line up with its results.
  always_ff @(posedge clk) begin
    if (rst || abort_act) begin
      for (int i = 0; i < Depth; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= accept ? {1'b1, sof, eol, eof} : 4'b0000;
      for (int i = 1; i < Depth; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign busy    = (state_q == StRun) || (state_q == StDrain);
  assign done    = (state_q == StDone);
  assign s_ready = (state_q == StRun);
  assign m_valid = tag_q[Depth-1][3];
  assign m_sof   = tag_q[Depth-1][2];
  assign m_eol   = tag_q[Depth-1][1];
  assign m_eof   = tag_q[Depth-1][0];
  assign m_luma  = luma_ch;
  assign m_cb    = cb_ch;
  assign m_cr    = cr_ch;

endmodule

// File: tb/tb_ycbcr_frame_ctrl.sv
// Bench for ycbcr_frame_ctrl (4x2 frame, one-cycle converter model); pixel table plus
// scoreboard of expected converter results and flags keyed by due cycle.
module tb_ycbcr_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0;
  logic       busy, done;
  logic       s_valid = 1'b0, s_ready;
  logic [7:0] s_red = '0, s_green = '0, s_blue = '0;
  logic [7:0] red_ch, green_ch, blue_ch;
  logic [7:0] luma_ch = '0, cb_ch = '0, cr_ch = '0;
  logic       m_valid, m_sof, m_eol, m_eof;
  logic [7:0] m_luma, m_cb, m_cr;

  ycbcr_frame_ctrl #(.IMG_W(4), .IMG_H(2), .CONV_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_red(s_red), .s_green(s_green),
    .s_blue(s_blue), .red_ch(red_ch), .green_ch(green_ch), .blue_ch(blue_ch),
    .luma_ch(luma_ch), .cb_ch(cb_ch), .cr_ch(cr_ch), .m_valid(m_valid),
    .m_luma(m_luma), .m_cb(m_cb), .m_cr(m_cr), .m_sof(m_sof), .m_eol(m_eol),
    .m_eof(m_eof)
  );

  always #5 clk = ~clk;

  // Converter model: one register stage.
  always @(posedge clk) begin
    luma_ch <= red_ch + green_ch;
    cb_ch   <= blue_ch ^ 8'h80;
    cr_ch   <= red_ch - blue_ch;
  end

  typedef struct {
    logic [7:0] r, g, b;
    logic       sof, eol, eof;
  } vec_t;

  typedef struct {
    int         due;
    logic [26:0] exp;  // {luma, cb, cr, sof, eol, eof}
  } sb_t;

  vec_t tbl [8];
  sb_t  sb [$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Output monitor: every m_valid must match the scoreboard head at its due cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_pixel: actual none required %0h due %0d", sb[0].exp, sb[0].due);
      void'(sb.pop_front());
    end
    if (m_valid === 1'b1) begin
      if (sb.size() == 0 || sb[0].due != cyc) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: actual m_valid=1 required m_valid=0 (cycle %0d)", cyc);
      end else begin
        check("pixel", {37'd0, m_luma, m_cb, m_cr, m_sof, m_eol, m_eof}, {37'd0, sb[0].exp});
        void'(sb.pop_front());
      end
      if (m_eof === 1'b1) exp_done_cyc = cyc + 1;
    end
    if (done === 1'b1 || cyc == exp_done_cyc)
      check("done_pulse", {63'd0, done}, {63'd0, cyc == exp_done_cyc});
  end

  // One cycle of stimulus; records the expected result of any accept it causes.
  task automatic drive(input logic v, input int idx, input logic st, input logic ab,
                       input logic rs, output logic acc);
    sb_t e;
    @(negedge clk);
    s_valid = v;
    s_red   = tbl[idx].r;
    s_green = tbl[idx].g;
    s_blue  = tbl[idx].b;
    start   = st;
    abort   = ab;
    rst     = rs;
    acc     = v && s_ready && !ab && !rs;
    if (rs || (ab && busy)) begin
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    end
    if (acc) begin
      e.due = cyc + 2;
      e.exp = {tbl[idx].r + tbl[idx].g, tbl[idx].b ^ 8'h80, tbl[idx].r - tbl[idx].b,
               tbl[idx].sof, tbl[idx].eol, tbl[idx].eof};
      sb.push_back(e);
    end
  endtask

  task automatic check_quiet(input string name);
    check(name, {34'd0, busy, done, s_ready, m_valid, m_sof, m_eol, m_eof, red_ch, green_ch,
                 blue_ch}, 64'd0);
  endtask

  task automatic run_frame(input bit gap, input bit mid_start);
    logic acc;
    int   idx = 0;
    int   k = 0;
    bit   seen = 0;
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
    while (idx < 8 && k < 40) begin
      drive(gap ? (k % 2 == 0) : 1'b1, idx, mid_start && idx == 2, 1'b0, 1'b0, acc);
      if (acc) idx++;
      k++;
    end
    check("frame_accepts", 64'(idx), 64'd8);
    for (int i = 0; i < 30 && !seen; i++) begin
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, acc);
      if (done === 1'b1) begin
        seen = 1;
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, acc);
    check("idle_after_done", {61'd0, busy, done, s_ready}, 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic acc;
    tbl[0] = '{r: 111, g: 3,   b: 122, sof: 1, eol: 0, eof: 0};
    tbl[1] = '{r: 121, g: 3,   b: 2,   sof: 0, eol: 0, eof: 0};
    tbl[2] = '{r: 10,  g: 200, b: 45,  sof: 0, eol: 0, eof: 0};
    tbl[3] = '{r: 255, g: 0,   b: 128, sof: 0, eol: 1, eof: 0};
    tbl[4] = '{r: 7,   g: 77,  b: 177, sof: 0, eol: 0, eof: 0};
    tbl[5] = '{r: 64,  g: 128, b: 192, sof: 0, eol: 0, eof: 0};
    tbl[6] = '{r: 0,   g: 255, b: 1,   sof: 0, eol: 0, eof: 0};
    tbl[7] = '{r: 33,  g: 99,  b: 250, sof: 0, eol: 1, eof: 1};

    // Reset then idle.
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, acc);
      check_quiet("reset_idle");
    end

    // Back-to-back frame, then gapped frame.
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);

    // Abort after 5 accepts.
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) drive(1'b1, i, 1'b0, 1'b0, 1'b0, acc);
    drive(1'b1, 5, 1'b0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 8; i++) drive(1'b0, 0, 1'b0, 1'b0, 1'b0, acc);
    check("abort_idle", {62'd0, busy, s_ready}, 64'd0);
    check("abort_sb_empty", 64'(sb.size()), 64'd0);
    run_frame(1'b0, 1'b0);

    // Start while busy has no effect.
    run_frame(1'b0, 1'b1);

    // Reset mid-frame after 3 accepts.
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) drive(1'b1, i, 1'b0, 1'b0, 1'b0, acc);
    drive(1'b1, 3, 1'b1, 1'b1, 1'b1, acc);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, acc);
    check_quiet("reset_mid_frame");
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b0, 1'b0, 1'b0, acc);
    check("rst_sb_empty", 64'(sb.size()), 64'd0);
    run_frame(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
